// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller:
// FSM state encoding, oversampling decision point and parity-type codes.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int unsigned OVERSAMPLE    = 8;
    localparam logic [2:0]  DECISION_EDGE = 3'(OVERSAMPLE - 1);

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Signal bundle between the RX line/sampler/consumer side (master) and the
// frame controller (slave).
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [3:0]            Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  Sampled_bit;
    logic [2:0]            Edge_count;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_valid;
    logic                  Par_err;
    logic                  Stp_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP, Sampled_bit,
        input  Edge_count, P_DATA, Data_valid, Par_err, Stp_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP, Sampled_bit,
        output Edge_count, P_DATA, Data_valid, Par_err, Stp_err
    );

endinterface

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter (wraps 7->0) and bit counter that advances on
// each edge-counter wrap; both hold while disabled and clear synchronously.
module edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [2:0] edge_count,
    output logic [3:0] bit_count
);

    logic [2:0] edge_q, edge_d;
    logic [3:0] bit_q,  bit_d;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        edge_d = edge_q;
        bit_d  = bit_q;
        if (clr) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (en) begin
            edge_d = edge_q + 3'd1;
            if (edge_q == DECISION_EDGE) begin
                bit_d = bit_q + 4'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

    assign edge_count = edge_q;
    assign bit_count  = bit_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detection, LSB-first deserialization,
// optional parity and stop checks, one-cycle result strobes.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    uart_rx_frame_ctrl_if.slave rx_if
);

    rx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  bad_q, bad_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;

    logic [2:0] edge_count;
    logic [3:0] bit_count;
    logic       cnt_en;
    logic       cnt_clr;
    logic       decision;
    logic       exp_parity;

    assign cnt_en     = (state_q != ST_IDLE);
    assign cnt_clr    = cnt_en && (state_d == ST_IDLE);
    assign decision   = (edge_count == 3'(rx_if.Prescale - 4'd1));
    assign exp_parity = (par_typ_q == PAR_EVEN) ? (^shift_q) : ~(^shift_q);

    edge_bit_counter u_edge_bit_counter (
        .clk        (Clk),
        .rst_n      (Rst),
        .en         (cnt_en),
        .clr        (cnt_clr),
        .edge_count (edge_count),
        .bit_count  (bit_count)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        bad_d        = bad_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!rx_if.RX_IN) begin
                    state_d   = ST_START;
                    par_en_d  = rx_if.PAR_EN;
                    par_typ_d = rx_if.PAR_TYP;
                end
            end
            ST_START: begin
                if (decision) begin
                    state_d = rx_if.Sampled_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (decision) begin
                    // Shifting in at the MSB leaves the first bit received at bit 0.
                    shift_d = {rx_if.Sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (bit_count == 4'(DATA_WIDTH)) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (decision) begin
                    if (rx_if.Sampled_bit != exp_parity) begin
                        par_err_d = 1'b1;
                        bad_d     = 1'b1;
                    end
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decision) begin
                    if (!rx_if.Sampled_bit) begin
                        stp_err_d = 1'b1;
                    end else if (!bad_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    bad_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= ST_IDLE;
            // NOTE: the shift register is a plain register file, not a memory, so it is reset with everything else.
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            bad_q        <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            bad_q        <= bad_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
        end
    end

    assign rx_if.Edge_count = edge_count;
    assign rx_if.P_DATA     = p_data_q;
    assign rx_if.Data_valid = data_valid_q;
    assign rx_if.Par_err    = par_err_q;
    assign rx_if.Stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: frames are driven bit-by-bit with an ideal
// sampler, and the expected strobes (kind, cycle, data) go through a scoreboard.
module tb_uart_rx_frame_ctrl;

    typedef enum logic [2:0] {
        EV_VALID = 3'b100,
        EV_PAR   = 3'b010,
        EV_STP   = 3'b001
    } ev_e;

    typedef struct {
        ev_e        kind;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   busy_until = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_frame_ctrl_if #(.DATA_WIDTH(8)) rx_if ();

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .Clk   (clk),
        .Rst   (rst_n),
        .rx_if (rx_if)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (rx_if.Data_valid || rx_if.Par_err || rx_if.Stp_err)) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe",
                      {29'd0, rx_if.Data_valid, rx_if.Par_err, rx_if.Stp_err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_kind", {29'd0, rx_if.Data_valid, rx_if.Par_err, rx_if.Stp_err},
                      {29'd0, mon_e.kind});
                check("strobe_cycle", cyc, mon_e.cyc);
                if (mon_e.kind == EV_VALID) begin
                    check("p_data", {24'd0, rx_if.P_DATA}, {24'd0, mon_e.data});
                end
            end
        end
    end

    // Drives one frame starting at the current negedge; bit b of the line is
    // driven for 8 cycles and the sampler output follows half a bit later.
    task automatic send_frame(input logic [7:0] data, input logic par_en, input logic par_typ,
                              input logic par_flip, input logic stop_bit, input logic flip_cfg);
        logic [10:0] bits;
        int          nbits;
        int          e0;
        int          done;
        logic        bad;
        bits    = '1;
        bits[0] = 1'b0;
        bits[8:1] = data;
        if (par_en) begin
            bits[9]  = (^data ^ par_typ) ^ par_flip;
            bits[10] = stop_bit;
            nbits    = 11;
        end else begin
            bits[9]  = stop_bit;
            nbits    = 10;
        end
        rx_if.PAR_EN  = par_en;
        rx_if.PAR_TYP = par_typ;

        // Start is seen at the next edge, or one edge after the previous frame ends.
        e0   = (cyc + 1 > busy_until + 1) ? cyc + 1 : busy_until + 1;
        done = e0 + (par_en ? 88 : 80);
        bad  = 1'b0;
        if (par_en && (bits[9] != (^data ^ par_typ))) begin
            sb.push_back('{EV_PAR, data, e0 + 80});
            bad = 1'b1;
        end
        if (!stop_bit) begin
            sb.push_back('{EV_STP, data, done});
        end else if (!bad) begin
            sb.push_back('{EV_VALID, data, done});
        end
        busy_until = done;

        for (int i = 0; i < nbits; i++) begin
            rx_if.RX_IN = bits[i];
            repeat (4) @(negedge clk);
            rx_if.Sampled_bit = bits[i];
            if (i == 0 && flip_cfg) begin
                rx_if.PAR_EN  = ~par_en;
                rx_if.PAR_TYP = ~par_typ;
            end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx_if.RX_IN = 1'b1;
        repeat (n) @(negedge clk);
        rx_if.Sampled_bit = 1'b1;
    endtask

    task automatic glitch();
        int e0;
        rx_if.RX_IN       = 1'b0;
        rx_if.Sampled_bit = 1'b1;
        e0 = (cyc + 1 > busy_until + 1) ? cyc + 1 : busy_until + 1;
        busy_until = e0 + 8;
        repeat (2) @(negedge clk);
        rx_if.RX_IN = 1'b1;
        while (cyc < e0 + 4) @(negedge clk);
        check("glitch_edge_mid", {29'd0, rx_if.Edge_count}, 32'd4);
        while (cyc < e0 + 8) @(negedge clk);
        check("glitch_edge_end", {29'd0, rx_if.Edge_count}, 32'd0);
        @(negedge clk);
        check("glitch_edge_idle", {29'd0, rx_if.Edge_count}, 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_edge"},  {29'd0, rx_if.Edge_count}, 32'd0);
        check({tag, "_pdata"}, {24'd0, rx_if.P_DATA},     32'd0);
        check({tag, "_dv"},    {31'd0, rx_if.Data_valid}, 32'd0);
        check({tag, "_perr"},  {31'd0, rx_if.Par_err},    32'd0);
        check({tag, "_serr"},  {31'd0, rx_if.Stp_err},    32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rx_if.RX_IN       = 1'b1;
        rx_if.Prescale    = 4'd8;
        rx_if.PAR_EN      = 1'b0;
        rx_if.PAR_TYP     = 1'b0;
        rx_if.Sampled_bit = 1'b1;
        rst_n             = 1'b0;
        #1;
        check_zero_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);
        // Even parity, correct bit; config inputs toggled mid-frame must be ignored.
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(20);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(20);
        check("p_data_hold_par", {24'd0, rx_if.P_DATA}, 32'h3C);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);
        check("p_data_hold_stp", {24'd0, rx_if.P_DATA}, 32'h3C);
        check("idle_after_stp", {29'd0, rx_if.Edge_count}, 32'd0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(20);

        glitch();
        idle(10);

        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);

        // Abort a frame in the middle of its data bits with reset.
        rx_if.RX_IN = 1'b0;
        repeat (4) @(negedge clk);
        rx_if.Sampled_bit = 1'b0;
        repeat (28) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rx_if.RX_IN       = 1'b1;
        rx_if.Sampled_bit = 1'b1;
        busy_until        = 0;
        rst_n             = 1'b1;
        @(negedge clk);
        check_zero_outputs("post_reset");

        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(20);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
